// File: rtl/park_gate_scheduler.sv
// Car-park barrier scheduler: round-robin arbitration of entry/exit lanes onto one
// shared barrier slot, with a free-place counter exported to the display.
module park_gate_scheduler #(
  parameter int NLANES     = 4,
  parameter int PMAX       = 5,
  parameter int BAR_CYCLES = 50,
  parameter int CW         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NLANES-1:0] entry_req,
  input  logic [NLANES-1:0] exit_req,
  output logic [NLANES-1:0] entry_open,
  output logic [NLANES-1:0] exit_open,
  output logic [CW-1:0]     free_cnt,
  output logic              full,
  output logic              empty
);

  localparam int PW = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int TW = (BAR_CYCLES > 2) ? $clog2(BAR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_timer;
  logic [PW-1:0]     r_ptr_in, r_ptr_out;
  logic [NLANES-1:0] r_arm_in, r_arm_out;
  logic [NLANES-1:0] r_entry_open, r_exit_open;
  logic [CW-1:0]     r_free;

  logic [NLANES-1:0] w_elig_in, w_elig_out;
  logic [PW:0]       w_pick_in, w_pick_out;
  logic [NLANES-1:0] w_gnt_in, w_gnt_out;
  logic              w_close;

  // {found, lane}: first eligible lane at or after ptr, wrapping modulo NLANES.
  function automatic logic [PW:0] rr_pick(input logic [NLANES-1:0] elig,
                                          input logic [PW-1:0]     ptr);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NLANES;
      if (elig[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
    return PW'((int'(g) + 1) % NLANES);
  endfunction

  // Full park blocks entries, empty park blocks exits; the requests stay pending.
  assign w_elig_in  = entry_req & r_arm_in  & {NLANES{r_free != '0}};
  assign w_elig_out = exit_req  & r_arm_out & {NLANES{r_free != CW'(PMAX)}};
  assign w_pick_in  = rr_pick(w_elig_in,  r_ptr_in);
  assign w_pick_out = rr_pick(w_elig_out, r_ptr_out);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_in    = '0;
    w_gnt_out   = '0;
    w_close     = 1'b0;
    case (r_state)
      IDLE: begin
        // Exits first: they free space and settle simultaneous entry/exit.
        if (w_pick_out[PW]) begin
          w_gnt_out   = NLANES'(1) << w_pick_out[PW-1:0];
          w_state_nxt = OPEN_OUT;
        end else if (w_pick_in[PW]) begin
          w_gnt_in    = NLANES'(1) << w_pick_in[PW-1:0];
          w_state_nxt = OPEN_IN;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (r_timer == TW'(BAR_CYCLES - 1)) begin
          w_close     = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP:     w_state_nxt = IDLE;
      default: begin
        w_close     = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_ptr_in     <= '0;
      r_ptr_out    <= '0;
      r_arm_in     <= '1;
      r_arm_out    <= '1;
      r_entry_open <= '0;
      r_exit_open  <= '0;
      r_free       <= CW'(PMAX);
    end else begin
      r_state   <= w_state_nxt;
      // Re-arm only once the lane's request drops: one car, one grant.
      r_arm_in  <= (r_arm_in  & ~w_gnt_in)  | ~entry_req;
      r_arm_out <= (r_arm_out & ~w_gnt_out) | ~exit_req;
      if (|w_gnt_out) begin
        r_exit_open  <= w_gnt_out;
        r_entry_open <= '0;
        r_free       <= r_free + CW'(1);
        r_ptr_out    <= ptr_after(w_pick_out[PW-1:0]);
        r_timer      <= '0;
      end else if (|w_gnt_in) begin
        r_entry_open <= w_gnt_in;
        r_exit_open  <= '0;
        r_free       <= r_free - CW'(1);
        r_ptr_in     <= ptr_after(w_pick_in[PW-1:0]);
        r_timer      <= '0;
      end else if (w_close) begin
        r_entry_open <= '0;
        r_exit_open  <= '0;
        r_timer      <= '0;
      end else if (r_state == OPEN_IN || r_state == OPEN_OUT) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  assign entry_open = r_entry_open;
  assign exit_open  = r_exit_open;
  assign free_cnt   = r_free;
  assign full       = (r_free == '0);
  assign empty      = (r_free == CW'(PMAX));

endmodule

// File: tb/tb_park_gate_scheduler.sv
// Scoreboard bench for park_gate_scheduler: a time-based reference model predicts
// barrier and counter outputs per edge; a monitor compares them against the DUT.
module tb_park_gate_scheduler;
  localparam int NL  = 4;
  localparam int PM  = 4;
  localparam int BAR = 4;
  localparam int CW  = 8;

  typedef struct {
    logic [NL-1:0] eo;
    logic [NL-1:0] xo;
    int            fc;
    logic          fu;
    logic          em;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] entry_req = '0;
  logic [NL-1:0] exit_req  = '0;
  logic [NL-1:0] entry_open, exit_open;
  logic [CW-1:0] free_cnt;
  logic          full, empty;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  logic [NL-1:0] m_arm_in, m_arm_out, m_eo, m_xo;
  int            m_free, m_pin, m_pout, m_last, m_edge;

  park_gate_scheduler #(.NLANES(NL), .PMAX(PM), .BAR_CYCLES(BAR), .CW(CW)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
    .entry_open(entry_open), .exit_open(exit_open),
    .free_cnt(free_cnt), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: a grant is allowed BAR+2 edges after the previous one; the open bit
  // lasts BAR edges; lanes are searched round-robin, exit side first.
  task automatic model_edge(input logic [NL-1:0] en, input logic [NL-1:0] ex, input logic r);
    int gi, go, l;
    exp_t e;
    m_edge++;
    if (r) begin
      m_free = PM; m_pin = 0; m_pout = 0; m_last = -100;
      m_arm_in = '1; m_arm_out = '1; m_eo = '0; m_xo = '0;
    end else begin
      gi = -1; go = -1;
      if (m_edge >= m_last + BAR + 2) begin
        for (int i = 0; i < NL; i++) begin
          l = (m_pout + i) % NL;
          if (go < 0 && ex[l] && m_arm_out[l] && m_free < PM) go = l;
        end
        if (go < 0)
          for (int i = 0; i < NL; i++) begin
            l = (m_pin + i) % NL;
            if (gi < 0 && en[l] && m_arm_in[l] && m_free > 0) gi = l;
          end
      end
      m_arm_in  = m_arm_in  | ~en;
      m_arm_out = m_arm_out | ~ex;
      if (go >= 0) begin
        m_arm_out[go] = 1'b0; m_free++; m_pout = (go + 1) % NL;
        m_eo = '0; m_xo = '0; m_xo[go] = 1'b1; m_last = m_edge;
      end else if (gi >= 0) begin
        m_arm_in[gi] = 1'b0; m_free--; m_pin = (gi + 1) % NL;
        m_xo = '0; m_eo = '0; m_eo[gi] = 1'b1; m_last = m_edge;
      end else if (m_edge == m_last + BAR) begin
        m_eo = '0; m_xo = '0;
      end
    end
    e.eo = m_eo; e.xo = m_xo; e.fc = m_free;
    e.fu = (m_free == 0); e.em = (m_free == PM);
    q.push_back(e);
  endtask

  task automatic cyc(input logic [NL-1:0] en, input logic [NL-1:0] ex, input logic r);
    @(negedge clk);
    entry_req = en; exit_req = ex; rst = r;
    model_edge(en, ex, r);
  endtask

  // Hold the given requests; each lane drops its request once it has been granted.
  task automatic run(input logic [NL-1:0] en0, input logic [NL-1:0] ex0, input int n);
    logic [NL-1:0] en, ex;
    en = en0; ex = ex0;
    repeat (n) begin
      cyc(en, ex, 1'b0);
      en = en & m_arm_in;
      ex = ex & m_arm_out;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("entry_open", int'(entry_open), int'(e.eo));
        check("exit_open",  int'(exit_open),  int'(e.xo));
        check("free_cnt",   int'(free_cnt),   e.fc);
        check("full",       int'(full),       int'(e.fu));
        check("empty",      int'(empty),      int'(e.em));
        check("onehot_open", int'($countones({entry_open, exit_open}) <= 1), 1);
      end
    end
  end

  initial begin : stim
    logic [NL-1:0] en, ex;
    m_edge = 0; m_last = -100;
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    // Held entry request gives a single grant until it falls and rises again.
    repeat (12) cyc(4'b0100, '0, 1'b0);
    repeat (2)  cyc('0, '0, 1'b0);
    repeat (10) cyc(4'b0100, '0, 1'b0);
    repeat (2)  cyc('0, '0, 1'b0);
    // Fill the park; lane 3 waits until an exit frees a place.
    run(4'b1011, '0, 40);
    run(4'b1000, 4'b0001, 30);
    // Simultaneous entry and exit: exit first.
    run(4'b0010, 4'b0100, 30);
    // All lanes request from lane-0 pointer.
    cyc('0, '0, 1'b1);
    run(4'b1111, '0, 40);
    // Reset in the middle of an exit opening.
    run('0, 4'b0001, 3);
    cyc('0, '0, 1'b1);
    run(4'b1000, '0, 12);
    // Exit blocked while empty until an entry happens.
    cyc('0, '0, 1'b1);
    run('0, 4'b0001, 8);
    run(4'b0001, 4'b0001, 30);
    // Randomized traffic with occasional resets.
    en = '0; ex = '0;
    repeat (3000) begin
      for (int l = 0; l < NL; l++) begin
        if (en[l] && !m_arm_in[l] && $urandom_range(0, 1) == 1) en[l] = 1'b0;
        else if ($urandom_range(0, 15) == 0) en[l] = ~en[l];
        if (ex[l] && !m_arm_out[l] && $urandom_range(0, 1) == 1) ex[l] = 1'b0;
        else if ($urandom_range(0, 15) == 0) ex[l] = ~ex[l];
      end
      cyc(en, ex, ($urandom_range(0, 399) == 0));
    end
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
